// File: rtl/serial_digit_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, one registered carry.
// Operands are captured once, then shifted out low digit first.
module serial_digit_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             V
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_carry;
    logic [CW-1:0]          r_cnt;
    logic                   r_co;
    logic                   r_v;

    logic                   w_accept;
    logic                   w_last;
    logic [DIGIT-1:0]       w_a_dig;
    logic [DIGIT-1:0]       w_b_dig;
    logic [DIGIT:0]         w_dsum;
    logic [DIGIT-1:0]       w_d;
    logic                   w_c;
    logic                   w_msb_cin;
    logic [WIDTH+DIGIT-1:0] w_sum_cat;

    assign w_accept  = (r_state == IDLE) && InValid;
    assign w_last    = (r_cnt == LAST);
    assign w_a_dig   = r_a[DIGIT-1:0];
    assign w_b_dig   = r_b[DIGIT-1:0];
    assign w_dsum    = {1'b0, w_a_dig} + {1'b0, w_b_dig}
                     + {{DIGIT{1'b0}}, r_carry};
    assign w_d       = w_dsum[DIGIT-1:0];
    assign w_c       = w_dsum[DIGIT];
    // Carry into the top bit of this digit, recovered from the sum bit.
    assign w_msb_cin = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_d[DIGIT-1];
    // New digit enters at the top while the sum register shifts right.
    assign w_sum_cat = {w_d, r_sum};

    assign S  = r_sum;
    assign CO = r_co;
    assign V  = r_v;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake outputs decoded from state only.
    always_comb begin
        w_next   = r_state;
        InReady  = 1'b0;
        OutValid = 1'b0;
        unique case (r_state)
            IDLE: begin
                InReady = 1'b1;
                if (InValid) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                OutValid = 1'b1;
                if (OutReady) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture, digit-serial datapath and result flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_co    <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= SUB ? ~B : B;
            r_carry <= CI;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_cat[WIDTH+DIGIT-1:DIGIT];
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_co <= w_c;
                r_v  <= w_msb_cin ^ w_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench for serial_digit_adder across several WIDTH/DIGIT configs.
// Config 0 (8/2) also runs the directed handshake, backpressure and reset cases.
module tb_serial_digit_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit done_flag [5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    for (genvar g = 0; g < 5; g++) begin : cfg
        localparam int W = (g == 4) ? 32 : 8;
        localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 :
                           (g == 3) ? 8 : 4;
        localparam int N = W / D;

        logic         rst  = 1'b1;
        logic         iv   = 1'b0;
        logic         ordy = 1'b1;
        logic         ci   = 1'b0;
        logic         sub  = 1'b0;
        logic [W-1:0] a    = '0;
        logic [W-1:0] b    = '0;
        logic         ir;
        logic         ov;
        logic         co;
        logic         v;
        logic [W-1:0] s;

        logic [W:0] q_cs [$];
        bit         q_v  [$];

        int ec = 0;
        int acc_e;
        int prev_acc;
        bit have_acc  = 1'b0;
        bit have_prev = 1'b0;
        bit b2b       = 1'b0;
        bit prev_ov   = 1'b0;

        serial_digit_adder #(
            .WIDTH(W),
            .DIGIT(D)
        ) u_dut (
            .CLK     (clk),
            .RST     (rst),
            .InValid (iv),
            .InReady (ir),
            .A       (a),
            .B       (b),
            .CI      (ci),
            .SUB     (sub),
            .OutValid(ov),
            .OutReady(ordy),
            .S       (s),
            .CO      (co),
            .V       (v)
        );

        always @(posedge clk) ec <= ec + 1;

        // Reference: plain wide arithmetic, signed overflow by range check.
        task automatic model(input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic eci, input logic esub,
                             output logic [W:0] cs, output bit ovf);
            logic [W-1:0] ob;
            longint       sv;
            longint       smax;
            longint       smin;
            ob   = esub ? ~eb : eb;
            cs   = {1'b0, ea} + {1'b0, ob} + (W+1)'(eci);
            sv   = longint'($signed(ea)) + longint'($signed(ob))
                 + longint'(eci);
            smax = (longint'(1) <<< (W - 1)) - 1;
            smin = -(longint'(1) <<< (W - 1));
            ovf  = (sv > smax) || (sv < smin);
        endtask

        // Monitor: latency, back-to-back spacing, and result scoreboard.
        always @(negedge clk) begin
            logic [W:0] ecs;
            bit         evf;
            if (rst) begin
                have_acc  = 1'b0;
                have_prev = 1'b0;
                prev_ov   = 1'b0;
            end else begin
                if (ov && !prev_ov) begin
                    chk($sformatf("cfg%0d latency", g),
                        have_acc ? longint'(ec - acc_e) : -1, N);
                    have_acc = 1'b0;
                end
                if (iv && ir) begin
                    if (b2b && have_prev) begin
                        chk($sformatf("cfg%0d spacing", g),
                            ec + 1 - prev_acc, N + 2);
                    end
                    prev_acc  = ec + 1;
                    have_prev = b2b;
                    acc_e     = ec + 1;
                    have_acc  = 1'b1;
                end
                if (ov && ordy) begin
                    if (q_cs.size() == 0) begin
                        chk($sformatf("cfg%0d spurious result", g), 1, 0);
                    end else begin
                        ecs = q_cs.pop_front();
                        evf = q_v.pop_front();
                        chk($sformatf("cfg%0d S", g), s, ecs[W-1:0]);
                        chk($sformatf("cfg%0d CO", g), co, ecs[W]);
                        chk($sformatf("cfg%0d V", g), v, evf);
                    end
                end
                prev_ov = ov;
            end
        end

        task automatic wait_ir();
            int k;
            k = 0;
            @(negedge clk);
            while (!ir && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (!ir) fail_now($sformatf("cfg%0d wait InReady", g));
        endtask

        task automatic issue(input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic eci, input logic esub,
                             input bit push, input bit keep);
            logic [W:0] cs;
            bit         vf;
            if (push) begin
                model(ea, eb, eci, esub, cs, vf);
                q_cs.push_back(cs);
                q_v.push_back(vf);
            end
            a   = ea;
            b   = eb;
            ci  = eci;
            sub = esub;
            iv  = 1'b1;
            wait_ir();
            @(posedge clk);
            #1;
            if (!keep) iv = 1'b0;
        endtask

        task automatic do_reset();
            rst  = 1'b1;
            iv   = 1'b0;
            ordy = 1'b1;
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
        endtask

        task automatic drain();
            int k;
            k = 0;
            while ((q_cs.size() != 0 || ov) && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (q_cs.size() != 0 || ov) fail_now($sformatf("cfg%0d drain", g));
            @(posedge clk);
            #1;
        endtask

        task automatic rand_ops(input int n);
            b2b  = 1'b1;
            ordy = 1'b1;
            for (int i = 0; i < n; i++) begin
                issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1, 1'b1);
            end
            iv  = 1'b0;
            b2b = 1'b0;
            drain();
        endtask

        task automatic chk_idle(input string tag);
            chk($sformatf("cfg%0d %s InReady", g, tag), ir, 1);
            chk($sformatf("cfg%0d %s OutValid", g, tag), ov, 0);
            chk($sformatf("cfg%0d %s S", g, tag), s, 0);
            chk($sformatf("cfg%0d %s CO", g, tag), co, 0);
            chk($sformatf("cfg%0d %s V", g, tag), v, 0);
        endtask

        if (g == 0) begin : gdir
            initial begin
                logic [W:0] hcs;
                bit         hvf;
                int         k;
                do_reset();
                @(negedge clk);
                chk_idle("reset");
                @(posedge clk);
                #1;
                issue(W'(8'hFF), W'(8'h01), 1'b0, 1'b0, 1'b1, 1'b0);
                issue(W'(8'h7F), W'(8'h01), 1'b0, 1'b0, 1'b1, 1'b0);
                issue(W'(8'h80), W'(8'h80), 1'b0, 1'b0, 1'b1, 1'b0);
                issue(W'(8'h05), W'(8'h07), 1'b1, 1'b1, 1'b1, 1'b0);
                issue(W'(8'h80), W'(8'h01), 1'b1, 1'b1, 1'b1, 1'b0);
                drain();

                ordy = 1'b0;
                model(W'(8'h3C), W'(8'h55), 1'b1, 1'b0, hcs, hvf);
                issue(W'(8'h3C), W'(8'h55), 1'b1, 1'b0, 1'b1, 1'b0);
                a  = W'(8'hAA);
                b  = W'(8'hAA);
                iv = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                iv = 1'b0;
                k  = 0;
                @(negedge clk);
                while (!ov && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                if (!ov) fail_now("cfg0 wait OutValid");
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("hold%0d OutValid", i), ov, 1);
                    chk($sformatf("hold%0d InReady", i), ir, 0);
                    chk($sformatf("hold%0d S", i), s, hcs[W-1:0]);
                    chk($sformatf("hold%0d CO", i), co, hcs[W]);
                    chk($sformatf("hold%0d V", i), v, hvf);
                    @(posedge clk);
                    #1;
                    iv = (i < 3);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                iv   = 1'b0;
                ordy = 1'b1;
                @(posedge clk);
                #1;
                @(negedge clk);
                chk("release InReady", ir, 1);
                chk("release OutValid", ov, 0);
                @(posedge clk);
                #1;

                issue(W'(8'hFF), W'(8'hFF), 1'b1, 1'b0, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk_idle("midrun reset");
                @(posedge clk);
                #1;
                issue(W'(8'h12), W'(8'h34), 1'b1, 1'b0, 1'b1, 1'b0);
                drain();

                rand_ops(40);
                done_flag[g] = 1'b1;
            end
        end else begin : grnd
            initial begin
                do_reset();
                @(negedge clk);
                chk_idle("reset");
                @(posedge clk);
                #1;
                rand_ops(40);
                done_flag[g] = 1'b1;
            end
        end
    end

    initial begin
        int  k;
        bit  all;
        k   = 0;
        all = 1'b0;
        while (!all && k < 60000) begin
            @(posedge clk);
            k++;
            all = 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (!done_flag[i]) all = 1'b0;
            end
        end
        if (!all) fail_now("global run");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
